// File: rtl/seven_segment_rx_if.sv
// Seven-segment display bus: segment/digit-enable lines from the driver and
// the decoded frame returned by the receiver.
interface seven_segment_rx_if;
  logic [6:0]  LED_out;
  logic        d0;
  logic        d1;
  logic        d2;
  logic        d3;
  logic [15:0] value;
  logic        valid;
  logic        err;

  modport master (
    output LED_out, d0, d1, d2, d3,
    input  value, valid, err
  );

  modport slave (
    input  LED_out, d0, d1, d2, d3,
    output value, valid, err
  );
endinterface

// File: rtl/seven_segment_rx.sv
// Decodes a multiplexed 4-digit seven-segment bus back into a 16-bit word,
// capturing each digit once it has been stable for SETTLE samples.
module seven_segment_rx #(
  parameter int unsigned SETTLE = 4
) (
  input logic               clk,
  input logic               rst,
  seven_segment_rx_if.slave bus
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_N  = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

  state_t             state, state_n;
  logic [SEG_W-1:0]   seg_q;
  logic [DIG_N-1:0]   dig_q;
  logic [SEG_W-1:0]   prev_pat;
  logic [1:0]         prev_idx;
  logic [CNT_W-1:0]   cnt, cnt_n, run_c;
  logic [WORD_W-1:0]  shadow, shadow_n;
  logic [DIG_N-1:0]   mask, mask_n;
  logic [WORD_W-1:0]  value_q, value_n;
  logic               valid_q, valid_n;
  logic               err_q, err_n;

  logic [SEG_W-1:0]   pat_c;
  logic [DIG_N-1:0]   en_c;
  logic               active_c;
  logic [1:0]         idx_c;
  logic               same_c;
  logic [NIB_W-1:0]   nib_c;
  logic               nib_ok_c;
  logic               capture_c;

  // Input register: everything downstream sees only the registered copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= '1;
      dig_q    <= '1;
      prev_pat <= '0;
      prev_idx <= '0;
    end else begin
      seg_q    <= bus.LED_out;
      dig_q    <= {bus.d3, bus.d2, bus.d1, bus.d0};
      prev_pat <= pat_c;
      prev_idx <= idx_c;
    end
  end

  assign pat_c    = ~seg_q;
  assign en_c     = ~dig_q;
  assign active_c = (en_c != '0) && ((en_c & (en_c - DIG_N'(1))) == '0);
  assign same_c   = (idx_c == prev_idx) && (pat_c == prev_pat);

  always_comb begin
    idx_c = 2'd0;
    case (en_c)
      4'b0010: idx_c = 2'd1;
      4'b0100: idx_c = 2'd2;
      4'b1000: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  // Logical abcdefg pattern to hex nibble; anything else is a bad digit.
  always_comb begin
    nib_c    = '0;
    nib_ok_c = 1'b1;
    case (pat_c)
      7'h7E: nib_c = 4'h0;
      7'h30: nib_c = 4'h1;
      7'h6D: nib_c = 4'h2;
      7'h79: nib_c = 4'h3;
      7'h33: nib_c = 4'h4;
      7'h5B: nib_c = 4'h5;
      7'h5F: nib_c = 4'h6;
      7'h70: nib_c = 4'h7;
      7'h7F: nib_c = 4'h8;
      7'h7B: nib_c = 4'h9;
      7'h77: nib_c = 4'hA;
      7'h1F: nib_c = 4'hB;
      7'h4E: nib_c = 4'hC;
      7'h3D: nib_c = 4'hD;
      7'h4F: nib_c = 4'hE;
      7'h47: nib_c = 4'hF;
      default: nib_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // run_c counts the current sample, so SETTLE = 1 captures on the first one.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_c     = '0;
    capture_c = 1'b0;
    if (!active_c) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (state == ST_HELD && same_c) begin
      state_n = ST_HELD;
    end else begin
      if (state == ST_SETTLE && same_c)
        run_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      else
        run_c = CNT_W'(1);
      cnt_n = run_c;
      if (run_c >= CNT_W'(SETTLE)) begin
        state_n   = ST_HELD;
        capture_c = 1'b1;
      end else begin
        state_n = ST_SETTLE;
      end
    end
  end

  // Frame assembly: the completing nibble is folded into value on the same edge.
  always_comb begin
    shadow_n = shadow;
    mask_n   = mask;
    value_n  = value_q;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    if (capture_c) begin
      if (nib_ok_c) begin
        shadow_n[{idx_c, 2'b00} +: NIB_W] = nib_c;
        mask_n = mask | (DIG_N'(1) << idx_c);
        if (mask_n == '1) begin
          value_n = shadow_n;
          valid_n = 1'b1;
          mask_n  = '0;
        end
      end else begin
        err_n  = 1'b1;
        mask_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      mask    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shadow  <= shadow_n;
      mask    <= mask_n;
      value_q <= value_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule
